// File: rtl/bus_pkg.sv
// Shared types and address map for the CPU bus controller (bus_ctrl) and its HRAM.
package bus_pkg;

    localparam int unsigned ADDR_W     = 16;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned HRAM_DEPTH = 127;
    localparam int unsigned HRAM_AW    = 7;
    localparam int unsigned CNT_W      = 3;

    localparam logic [ADDR_W-1:0] BOOT_ROM_LAST = 16'h00FF;
    localparam logic [ADDR_W-1:0] BOOT_REG_ADDR = 16'hFF50;
    localparam logic [ADDR_W-1:0] HRAM_BASE     = 16'hFF80;
    localparam logic [ADDR_W-1:0] HRAM_LAST     = 16'hFFFE;

    typedef enum logic [1:0] {
        REGION_CART,
        REGION_ROM,
        REGION_BOOT,
        REGION_HRAM
    } region_e;

    typedef enum logic [2:0] {
        IDLE,
        ROM_RD,
        CART_RD,
        CART_WR,
        DONE
    } state_e;

    // Attributes of the accepted request that the completion state still needs.
    typedef struct packed {
        logic    is_rd;
        region_e region;
    } req_t;

    function automatic region_e decode_region(input logic [ADDR_W-1:0] addr,
                                              input logic              boot_en);
        region_e region;
        region = REGION_CART;
        if (boot_en && (addr <= BOOT_ROM_LAST)) begin
            region = REGION_ROM;
        end else if (addr == BOOT_REG_ADDR) begin
            region = REGION_BOOT;
        end else if ((addr >= HRAM_BASE) && (addr <= HRAM_LAST)) begin
            region = REGION_HRAM;
        end
        return region;
    endfunction

endpackage

// File: rtl/hram.sv
// 127x8 high RAM with one-cycle registered read; every entry returns to INIT on reset.
module hram
    import bus_pkg::*;
#(
    parameter logic [DATA_W-1:0] INIT = 8'h00
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               we_i,
    input  logic               re_i,
    input  logic [HRAM_AW-1:0] addr_i,
    input  logic [DATA_W-1:0]  wdata_i,
    output logic [DATA_W-1:0]  rdata_o
);

    logic [DATA_W-1:0] mem_q [HRAM_DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < HRAM_DEPTH; i++) begin
                mem_q[HRAM_AW'(i)] <= INIT;
            end
            rdata_q <= INIT;
        end else begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
            end
            if (re_i) begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/bus_ctrl.sv
// CPU memory bus controller: boot ROM overlay, 0xFF50 boot register, HRAM and cartridge port.
// Boot overlay and boot register are built only when BOOT_OVERLAY_EN is defined.
module bus_ctrl
    import bus_pkg::*;
#(
    parameter int unsigned       CART_LAT  = 1,
    parameter logic [DATA_W-1:0] HRAM_INIT = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_cs,
    input  logic              mem_oe,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] addr_bus,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic [7:0]        rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [ADDR_W-1:0] cart_addr,
    output logic              cart_rd,
    output logic              cart_wr,
    output logic [DATA_W-1:0] cart_wdata,
    input  logic [DATA_W-1:0] cart_rdata,
    output logic              boot_en
);

`ifdef BOOT_OVERLAY_EN
    localparam logic OVERLAY = 1'b1;
`else
    localparam logic OVERLAY = 1'b0;
`endif

    localparam logic [CNT_W-1:0] CART_WAIT = CNT_W'(CART_LAT - 1);

    state_e            state_q, state_d;
    req_t              req_q, req_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [7:0]        rom_addr_q, rom_addr_d;
    logic [ADDR_W-1:0] cart_addr_q, cart_addr_d;
    logic [DATA_W-1:0] cart_wdata_q, cart_wdata_d;
    logic              cart_rd_q, cart_rd_d;
    logic              cart_wr_q, cart_wr_d;
    logic              boot_en_q, boot_en_d;

    logic              accept_c;
    region_e           region_c;
    logic [DATA_W-1:0] hram_rdata;
    logic [DATA_W-1:0] boot_rd_c;

    // busy_q is still high during the rd_valid cycle, which keeps IDLE from accepting then.
    assign accept_c  = (state_q == IDLE) && !busy_q && mem_cs && (mem_oe ^ mem_we);
    assign region_c  = decode_region(addr_bus, boot_en_q & OVERLAY);
    assign boot_rd_c = OVERLAY ? {7'h7F, ~boot_en_q} : 8'hFF;

    // HRAM is addressed straight from the bus so its data is ready one cycle after accept.
    hram #(
        .INIT (HRAM_INIT)
    ) u_hram (
        .clk     (clk),
        .rst_n   (rst),
        .we_i    (accept_c && mem_we && (region_c == REGION_HRAM)),
        .re_i    (accept_c && mem_oe && (region_c == REGION_HRAM)),
        .addr_i  (addr_bus[HRAM_AW-1:0]),
        .wdata_i (wr_data),
        .rdata_o (hram_rdata)
    );

    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        cnt_d        = cnt_q;
        busy_d       = busy_q;
        rd_valid_d   = 1'b0;
        rd_data_d    = rd_data_q;
        rom_addr_d   = rom_addr_q;
        cart_addr_d  = cart_addr_q;
        cart_wdata_d = cart_wdata_q;
        cart_rd_d    = cart_rd_q;
        cart_wr_d    = 1'b0;
        boot_en_d    = boot_en_q;

        unique case (state_q)
            IDLE: begin
                if (busy_q) begin
                    busy_d = 1'b0;
                end else if (accept_c) begin
                    busy_d       = 1'b1;
                    req_d.is_rd  = mem_oe;
                    req_d.region = region_c;
                    state_d      = DONE;
                    case (region_c)
                        REGION_ROM: begin
                            // Writes into the overlaid ROM window are dropped.
                            if (mem_oe) begin
                                rom_addr_d = addr_bus[7:0];
                                state_d    = ROM_RD;
                            end
                        end
                        REGION_BOOT: begin
                            if (OVERLAY && mem_we && wr_data[0]) begin
                                boot_en_d = 1'b0;
                            end
                        end
                        REGION_CART: begin
                            cart_addr_d = addr_bus;
                            if (mem_oe) begin
                                cart_rd_d = 1'b1;
                                cnt_d     = CART_WAIT;
                                state_d   = CART_RD;
                            end else begin
                                cart_wdata_d = wr_data;
                                cart_wr_d    = 1'b1;
                                state_d      = CART_WR;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ROM_RD: begin
                state_d = DONE;
            end
            CART_RD: begin
                if (cnt_q == '0) begin
                    cart_rd_d  = 1'b0;
                    rd_data_d  = cart_rdata;
                    rd_valid_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            CART_WR: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            DONE: begin
                state_d = IDLE;
                if (req_q.is_rd) begin
                    rd_valid_d = 1'b1;
                    case (req_q.region)
                        REGION_ROM:  rd_data_d = rom_data;
                        REGION_BOOT: rd_data_d = boot_rd_c;
                        REGION_HRAM: rd_data_d = hram_rdata;
                        default:     rd_data_d = cart_rdata;
                    endcase
                end else begin
                    busy_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            req_q        <= '{is_rd: 1'b0, region: REGION_CART};
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
            rom_addr_q   <= '0;
            cart_addr_q  <= '0;
            cart_wdata_q <= '0;
            cart_rd_q    <= 1'b0;
            cart_wr_q    <= 1'b0;
            boot_en_q    <= OVERLAY;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
            rd_valid_q   <= rd_valid_d;
            rd_data_q    <= rd_data_d;
            rom_addr_q   <= rom_addr_d;
            cart_addr_q  <= cart_addr_d;
            cart_wdata_q <= cart_wdata_d;
            cart_rd_q    <= cart_rd_d;
            cart_wr_q    <= cart_wr_d;
            boot_en_q    <= boot_en_d;
        end
    end

    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign busy       = busy_q;
    assign rom_addr   = rom_addr_q;
    assign cart_addr  = cart_addr_q;
    assign cart_rd    = cart_rd_q;
    assign cart_wr    = cart_wr_q;
    assign cart_wdata = cart_wdata_q;
    assign boot_en    = boot_en_q;

endmodule
